instr_fetch_queue: RTL

- Front-end stage directly upstream of the decode/execute pipeline.
- Issues word-aligned instruction reads to the instruction-memory port of the memory controller and buffers returned {pc, instr} pairs in a small FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and squashing the in-flight read.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h1000_0000;

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic [PW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = PW - 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_count = wr_ptr - rd_ptr;
    assign o_head  = mem[rd_ptr[AW-1:0]];
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_flush) mem[wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues reads, buffers {pc, instr}, handles redirects.
// Define FETCH_STATS_EN to add fetched/squashed/stall counters as extra outputs.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] INIT_PC = FETCH_RESET_PC,
    parameter int          DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    input  logic        i_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] o_stat_fetched,
    output logic [31:0] o_stat_squashed,
    output logic [31:0] o_stat_stall
`endif
);

    localparam int              PW      = ptr_width(DEPTH);
    localparam logic [PW:0]     DEPTH_W = (PW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   redirect_addr;
    logic          inflight;
    logic          grant;
    logic          squash;
    logic          resp_push;
    logic          pop;
    logic [PW-1:0] count;
    logic [PW:0]   used;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    fetch_entry_t  out_q;
    logic          unused_ok;

    assign unused_ok     = ^{fifo_full, i_redirect_pc[1:0]};
    assign redirect_addr = {i_redirect_pc[31:2], 2'b00};
    assign used          = {1'b0, count} + {{PW{1'b0}}, inflight};

    // Request is held off during reset so nothing is granted while state is clearing.
    assign o_imem_req  = i_rst_n & ((used < DEPTH_W) | i_redirect);
    assign o_imem_addr = i_redirect ? redirect_addr : fetch_pc;
    assign grant       = o_imem_req & i_imem_gnt;

    // Memory latency is one cycle, so a response arriving in a redirect cycle is stale.
    assign squash    = inflight & i_redirect;
    assign resp_push = inflight & ~i_redirect;
    assign push_data = '{pc: inflight_pc, instr: i_imem_rdata};

    assign o_valid = ~fifo_empty;
    assign pop     = o_valid & i_ready & ~i_redirect;
    assign o_pc    = o_valid ? head.pc    : out_q.pc;
    assign o_instr = o_valid ? head.instr : out_q.instr;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (resp_push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .i_flush     (i_redirect),
        .o_head      (head),
        .o_count     (count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc    <= INIT_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            out_q       <= '0;
        end else begin
            if (grant) begin
                fetch_pc    <= o_imem_addr + 32'd4;
                inflight_pc <= o_imem_addr;
            end else if (i_redirect) begin
                fetch_pc <= redirect_addr;
            end
            inflight <= grant;
            if (o_valid) out_q <= head;
        end
    end

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] squash_inc;
    assign squash_inc = (i_redirect ? 32'(count) : 32'd0) + 32'(squash);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_fetched  <= '0;
            o_stat_squashed <= '0;
            o_stat_stall    <= '0;
        end else begin
            o_stat_fetched  <= sat_add(o_stat_fetched, 32'(pop));
            o_stat_squashed <= sat_add(o_stat_squashed, squash_inc);
            o_stat_stall    <= sat_add(o_stat_stall, 32'(~o_valid & i_ready));
        end
    end
`endif

endmodule
